mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single mem_system instance between the fetch stage (read-only instruction port) and the memory stage (read/write data port).
- Selects one requester at a time and holds the grant until the memory signals Done. Routes Done, DataOut and err back to the owner and stalls the other port.
- Data port has priority; a bounded-streak counter guarantees fetch forward progress.

Parameters:
- MAX_DATA_STREAK, 4: max consecutive data grants while a fetch is pending; the next arbitration then goes to fetch.
- STREAK_W, 3: counter width; must hold MAX_DATA_STREAK.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- I_Addr  in  16  fetch address
- I_Rd  in  1  fetch request, held until I_Done
- I_DataOut  out  16  fetch read data
- I_Done  out  1  fetch completion pulse
- I_Stall  out  1  fetch must hold
- D_Addr  in  16  data address
- D_DataIn  in  16  store data
- D_Rd  in  1  load request, held until D_Done
- D_Wr  in  1  store request, held until D_Done
- D_DataOut  out  16  load data
- D_Done  out  1  data completion pulse
- D_Stall  out  1  data port must hold
- M_Addr  out  16  to mem_system Addr
- M_DataIn  out  16  to mem_system DataIn
- M_Rd  out  1  to mem_system Rd
- M_Wr  out  1  to mem_system Wr
- M_DataOut  in  16  from mem_system DataOut
- M_Done  in  1  from mem_system Done
- M_err  in  1  from mem_system err
- err  out  1  error: M_err during an owned access, or protocol violation

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- State: IDLE, SERVE_I, SERVE_D (registered); streak counter (registered).
- Request definitions: dreq = D_Rd|D_Wr; ireq = I_Rd.
- IDLE arbitration (combinational, same cycle):
  - Pick D if dreq and not (ireq and streak==MAX_DATA_STREAK).
  - Else pick I if ireq.
  - Else none.
- IDLE drive: the winner's Addr/DataIn/Rd/Wr drive M_* this cycle, so the access starts with zero added latency. Next state is SERVE_D/SERVE_I; if M_Done is already high in that cycle, the access completes and the state stays IDLE.
- SERVE_x: M_* driven from the owner's inputs every cycle. On M_Done the state moves to IDLE next cycle; otherwise it holds. The non-owner is never driven to memory.
- Non-owner port: M_Addr/M_DataIn = 0 and M_Rd = M_Wr = 0 when there is no owner.
- Done/data routing:
  - Owner x: x_Done = M_Done; x_DataOut = M_DataOut in the owner's Done cycle, else 0.
  - Non-owner: Done = 0; DataOut = 0.
- Stall: x_Stall = x request active & ~x_Done. Asserted from the first request cycle through the cycle before Done, including while waiting for the grant.
- Streak counter:
  - Data grant issued while ireq is high: streak+1, saturating at MAX_DATA_STREAK.
  - Fetch grant issued, or ireq low in IDLE: streak = 0.
- Back-to-back: requester drops its request the cycle after Done. A request held high is treated as new and re-arbitrated in IDLE, so there is a minimum 1 idle cycle between accesses.
- err (combinational):
  - M_err while an owner exists, or
  - D_Rd&D_Wr both high, or
  - owner's Addr changes during SERVE_x relative to the value captured at grant.
  - Address captured in a 16-bit register at grant.
- Reset: state=IDLE, streak=0, captured addr=0.
  - All outputs 0 while rst is high, regardless of inputs.
  - Reset mid-access abandons the access; no Done is delivered. mem_system shares rst.

Test Plan:
- Single fetch: I_Rd=1, I_Addr=0x0010, M_Done high 3 cycles later with M_DataOut=0xBEEF -> M_Rd=1 and M_Addr=0x0010 from cycle 0; I_Stall=1 for cycles 0-2; cycle 3 I_Done=1, I_DataOut=0xBEEF, I_Stall=0; D_* stay 0.
- Simultaneous requests: I_Rd=1 at 0x0020, D_Wr=1 at 0x4000 with D_DataIn=0x1234 in the same cycle -> M_Wr=1, M_Addr=0x4000, M_DataIn=0x1234 first; I_Stall=1 throughout. After D_Done, one IDLE cycle, then M_Rd=1 with M_Addr=0x0020.
- Starvation bound (MAX_DATA_STREAK=4): I_Rd held, D_Rd re-asserted after every Done -> exactly 4 data accesses, then fetch granted. Streak returns to 0 after the fetch grant.
- Protocol error: D_Rd=D_Wr=1 -> err=1 that cycle. Owner changes D_Addr 0x4000->0x4002 mid-SERVE_D -> err=1. M_err=1 during SERVE_I -> err=1.
- Reset mid-operation: rst=1 during SERVE_D, before M_Done -> next cycle state IDLE, all outputs 0, no D_Done. After rst drops with D_Rd held, the access restarts with M_Rd=1.
- Zero-latency hit: D_Rd=1 with M_Done=1 in the same IDLE cycle -> D_Done=1 that cycle; state stays IDLE next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one mem_system between the fetch port (read only)
// and the data port (read/write). The data port normally wins, and a streak
// counter hands the next grant to a pending fetch after MAX_DATA_STREAK
// consecutive data grants. A grant is held until the memory raises Done.
module mem_port_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int STREAK_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic [15:0] I_Addr,
  input  logic        I_Rd,
  output logic [15:0] I_DataOut,
  output logic        I_Done,
  output logic        I_Stall,
  // data port
  input  logic [15:0] D_Addr,
  input  logic [15:0] D_DataIn,
  input  logic        D_Rd,
  input  logic        D_Wr,
  output logic [15:0] D_DataOut,
  output logic        D_Done,
  output logic        D_Stall,
  // mem_system side
  output logic [15:0] M_Addr,
  output logic [15:0] M_DataIn,
  output logic        M_Rd,
  output logic        M_Wr,
  input  logic [15:0] M_DataOut,
  input  logic        M_Done,
  input  logic        M_err,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [15:0]         addr_q, addr_d;

  logic dreq, ireq;
  logic own_d, own_i;

  assign dreq = D_Rd | D_Wr;
  assign ireq = I_Rd;

  // Arbitration, owner selection, next state, streak and captured address.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    own_d    = 1'b0;
    own_i    = 1'b0;
    case (state_q)
      IDLE: begin
        // Data wins unless a fetch has waited through a full data streak.
        own_d = dreq && !(ireq && (streak_q == STREAK_MAX));
        own_i = !own_d && ireq;
        if (own_d) begin
          addr_d  = D_Addr;
          state_d = M_Done ? IDLE : SERVE_D;
          if (ireq) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q
                                                : streak_q + STREAK_W'(1);
          end
        end else if (own_i) begin
          addr_d   = I_Addr;
          state_d  = M_Done ? IDLE : SERVE_I;
          streak_d = '0;
        end
        if (!ireq) begin
          streak_d = '0;
        end
      end
      SERVE_I: begin
        own_i = 1'b1;
        if (M_Done) state_d = IDLE;
      end
      SERVE_D: begin
        own_d = 1'b1;
        if (M_Done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory drive, completion routing, stalls and error; all forced low in reset.
  always_comb begin
    M_Addr    = '0;
    M_DataIn  = '0;
    M_Rd      = 1'b0;
    M_Wr      = 1'b0;
    I_Done    = 1'b0;
    I_DataOut = '0;
    I_Stall   = 1'b0;
    D_Done    = 1'b0;
    D_DataOut = '0;
    D_Stall   = 1'b0;
    err       = 1'b0;
    if (!rst) begin
      if (own_d) begin
        M_Addr   = D_Addr;
        M_DataIn = D_DataIn;
        M_Rd     = D_Rd;
        M_Wr     = D_Wr;
        D_Done   = M_Done;
      end else if (own_i) begin
        M_Addr = I_Addr;
        M_Rd   = I_Rd;
        I_Done = M_Done;
      end
      if (D_Done) D_DataOut = M_DataOut;
      if (I_Done) I_DataOut = M_DataOut;
      D_Stall = dreq & ~D_Done;
      I_Stall = ireq & ~I_Done;
      err = (M_err & (own_d | own_i))
          | (D_Rd & D_Wr)
          | ((state_q == SERVE_D) && (D_Addr != addr_q))
          | ((state_q == SERVE_I) && (I_Addr != addr_q));
    end
  end

  // State, streak and captured-address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
    end
  end

endmodule
